// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with synchronous clear, clamped parallel load,
// combinational terminal count and Gray view, plus a sticky wrap flag.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    input  logic             Up,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] Gray,
    output logic             Tc,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             tc;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;

    initial begin : param_check
        assert (WIDTH >= 1) else $error("WIDTH must be >= 1");
        assert (MODULUS >= 2 && MODULUS <= (2 ** WIDTH))
            else $error("MODULUS out of range");
    end

    always_comb begin
        tc = En & ((Up & (out_q == MAX_VAL)) | (~Up & (out_q == ZERO)));
    end

    // Out-of-range values (unreachable with legal parameters) snap to the
    // wrap target of the current direction.
    always_comb begin
        load_val = (D > MAX_VAL) ? MAX_VAL : D;
        up_val   = (out_q >= MAX_VAL) ? ZERO : out_q + ONE;
        dn_val   = ((out_q == ZERO) || (out_q > MAX_VAL)) ? MAX_VAL : out_q - ONE;
    end

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (Clr) begin
            out_d = ZERO;
            ovf_d = 1'b0;
        end else if (Load) begin
            out_d = load_val;
        end else if (En) begin
            out_d = Up ? up_val : dn_val;
            if (tc) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out  = out_q;
    assign Gray = out_q ^ (out_q >> 1);
    assign Tc   = tc;
    assign Ovf  = ovf_q;

endmodule
